// File: rtl/mac_cplx_sched.sv
// mac_cplx_sched: complex multiply-accumulate sequencer that shares one
// external 4x4 unsigned multiplier.  Each accepted operand set issues four
// products one at a time, then combines them into (re, im) and loads or
// accumulates them into ACC_W-bit signed accumulators.
//
// Ports
//   clk, rst                     clock, async active-low reset
//   in_valid/in_ready            operand handshake (ready only in IDLE)
//   in_ar/in_ai/in_br/in_bi      unsigned 4-bit operands, A = ar+j*ai, B = br+j*bi
//   in_acc                       1 = accumulate, 0 = overwrite
//   clr                          clears accumulators/ovf/err (IDLE only)
//   mul_start/mul_a/mul_b        request to the shared multiplier
//   mul_done/mul_p               multiplier done level and product
//   out_valid/out_ready          result handshake
//   out_re/out_im                accumulator values
//   ovf, err                     sticky wrap / multiplier-timeout flags
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for an operand set, clr honoured here
// ISSUE   | one-cycle mul_start for product k, timeout counter cleared
// WAIT_LO | waiting for mul_done to drop (multiplier took the request)
// WAIT_HI | waiting for mul_done to rise, then capture product k
// COMBINE | form re/im and update the accumulators
// OUT     | result presented until out_ready
module mac_cplx_sched #(
   parameter int ACC_W = 12,
   parameter int TMO   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_ar,
   input  logic [3:0]              in_ai,
   input  logic [3:0]              in_br,
   input  logic [3:0]              in_bi,
   input  logic                    in_acc,
   input  logic                    clr,
   output logic                    mul_start,
   output logic [3:0]              mul_a,
   output logic [3:0]              mul_b,
   input  logic                    mul_done,
   input  logic [7:0]              mul_p,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_re,
   output logic signed [ACC_W-1:0] out_im,
   output logic                    ovf,
   output logic                    err
);

   localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, COMBINE, OUT} state_t;

   state_t                  st, nxt;
   logic [1:0]              k;
   logic [TW-1:0]           tmo_cnt;
   logic                    tmo_hit;
   logic [3:0]              ar_q, ai_q, br_q, bi_q;
   logic                    acc_q;
   logic [7:0]              p [4];
   logic signed [ACC_W-1:0] acc_re, acc_im;
   logic signed [9:0]       re_w, im_w;
   logic signed [ACC_W:0]   sum_re, sum_im;
   logic                    sum_ovf;

   assign tmo_hit = (tmo_cnt == TW'(TMO));
   assign out_re  = acc_re;
   assign out_im  = acc_im;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= IDLE;
      else      st <= nxt;
   end

   always_comb begin
      nxt       = st;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      out_valid = 1'b0;
      case (st)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nxt = ISSUE;
         end
         ISSUE: begin
            mul_start = 1'b1;
            nxt       = WAIT_LO;
         end
         WAIT_LO: begin
            if (tmo_hit)        nxt = IDLE;
            else if (!mul_done) nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (tmo_hit)       nxt = IDLE;
            else if (mul_done) nxt = (k == 2'd3) ? COMBINE : ISSUE;
         end
         COMBINE: nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Operands follow k, which only advances at capture, so they stay
   // stable from ISSUE through the capture cycle.
   always_comb begin
      mul_a = ar_q;
      mul_b = br_q;
      case (k)
         2'd0: begin mul_a = ar_q; mul_b = br_q; end
         2'd1: begin mul_a = ai_q; mul_b = bi_q; end
         2'd2: begin mul_a = ar_q; mul_b = bi_q; end
         2'd3: begin mul_a = ai_q; mul_b = br_q; end
         default: ;
      endcase
   end

   // One extra bit of headroom gives the exact sum; wrap is detected when
   // the top two bits disagree.
   always_comb begin
      re_w    = $signed({2'b00, p[0]}) - $signed({2'b00, p[1]});
      im_w    = $signed({2'b00, p[2]}) + $signed({2'b00, p[3]});
      sum_re  = (ACC_W+1)'(re_w);
      sum_im  = (ACC_W+1)'(im_w);
      if (acc_q) begin
         sum_re = sum_re + {acc_re[ACC_W-1], acc_re};
         sum_im = sum_im + {acc_im[ACC_W-1], acc_im};
      end
      sum_ovf = (sum_re[ACC_W] != sum_re[ACC_W-1]) || (sum_im[ACC_W] != sum_im[ACC_W-1]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k       <= 2'd0;
         tmo_cnt <= '0;
         ar_q    <= 4'd0;
         ai_q    <= 4'd0;
         br_q    <= 4'd0;
         bi_q    <= 4'd0;
         acc_q   <= 1'b0;
         for (int i = 0; i < 4; i++) p[i] <= 8'd0;
         acc_re  <= '0;
         acc_im  <= '0;
         ovf     <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               // clr and accept in the same cycle: the new set sees base 0
               if (clr) begin
                  acc_re <= '0;
                  acc_im <= '0;
                  ovf    <= 1'b0;
                  err    <= 1'b0;
               end
               if (in_valid) begin
                  ar_q  <= in_ar;
                  ai_q  <= in_ai;
                  br_q  <= in_br;
                  bi_q  <= in_bi;
                  acc_q <= in_acc;
                  k     <= 2'd0;
               end
            end
            ISSUE: tmo_cnt <= '0;
            WAIT_LO: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_hit) err <= 1'b1;
            end
            WAIT_HI: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_hit) err <= 1'b1;
               else if (mul_done) begin
                  p[k] <= mul_p;
                  if (k != 2'd3) k <= k + 2'd1;
               end
            end
            COMBINE: begin
               acc_re <= sum_re[ACC_W-1:0];
               acc_im <= sum_im[ACC_W-1:0];
               if (sum_ovf) ovf <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_cplx_sched.sv
// Directed bench for mac_cplx_sched with a behavioural shared multiplier
// whose done level drops the cycle after start and stays low K cycles.
module tb_mac_cplx_sched;

   localparam int ACC_W = 12;
   localparam int TMO   = 16;
   localparam int K     = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0, in_acc = 1'b0, clr = 1'b0, out_ready = 1'b0;
   logic [3:0] in_ar = 4'd0, in_ai = 4'd0, in_br = 4'd0, in_bi = 4'd0;
   logic in_ready, mul_start, out_valid, ovf, err;
   logic [3:0] mul_a, mul_b;
   logic mul_done = 1'b1;
   logic [7:0] mul_p = 8'd0;
   logic signed [ACC_W-1:0] out_re, out_im;

   int total = 0;
   int bad = 0;
   int n_start = 0;
   int hang_base = 0;
   logic hang_en = 1'b0;
   int lo_cnt = 0;

   mac_cplx_sched #(.ACC_W(ACC_W), .TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
      .in_acc(in_acc), .clr(clr),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   // Multiplier model; with hang_en it ignores the 2nd start of the set.
   always @(posedge clk) begin
      if (mul_start) begin
         n_start <= n_start + 1;
         if (!(hang_en && (n_start - hang_base) >= 1)) begin
            mul_done <= 1'b0;
            lo_cnt   <= K - 1;
            mul_p    <= mul_a * mul_b;
         end
      end else if (!mul_done) begin
         if (lo_cnt == 0) mul_done <= 1'b1;
         else             lo_cnt   <= lo_cnt - 1;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] ar, ai, br, bi, input logic acc);
      in_ar = ar; in_ai = ai; in_br = br; in_bi = bi; in_acc = acc;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_after_out", int'(in_ready), 1);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   // Accept one set, measure latency from the accept cycle, check result.
   task automatic run_set(input string tag, input logic [3:0] ar, ai, br, bi,
                          input logic acc, input int exp_re, exp_im, input bit do_consume);
      int s0, lat;
      s0 = n_start;
      chk({tag, "_ready"}, int'(in_ready), 1);
      send(ar, ai, br, bi, acc);
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, 4 * K + 10);
      chk({tag, "_re"}, int'(out_re), exp_re);
      chk({tag, "_im"}, int'(out_im), exp_im);
      chk({tag, "_starts"}, n_start - s0, 4);
      if (do_consume) consume();
   endtask

   initial begin
      int s0, s1, cyc, saw;
      bit stable, rdy_seen;

      // reset state
      #1;
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_start", int'(mul_start), 0);
      chk("rst_mula", int'(mul_a), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_re", int'(out_re), 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // basic
      run_set("basic", 4'd2, 4'd2, 4'd1, 4'd2, 1'b0, -2, 6, 1'b1);

      // accumulate
      run_set("acc1", 4'd2, 4'd3, 4'd2, 4'd1, 1'b0, 1, 8, 1'b1);
      run_set("acc2", 4'd1, 4'd0, 4'd1, 4'd3, 1'b1, 2, 11, 1'b1);

      // backpressure, then clr
      run_set("bp", 4'd2, 4'd2, 4'd1, 4'd2, 1'b0, -2, 6, 1'b0);
      s0 = n_start;
      stable = 1'b1;
      rdy_seen = 1'b0;
      in_ar = 4'd7; in_ai = 4'd7; in_br = 4'd7; in_bi = 4'd7; in_acc = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_re != -2 || out_im != 6 || !out_valid) stable = 1'b0;
         if (in_ready) rdy_seen = 1'b1;
      end
      in_valid = 1'b0;
      chk("bp_stable", int'(stable), 1);
      chk("bp_ready", int'(rdy_seen), 0);
      chk("bp_nostart", n_start - s0, 0);
      consume();
      pulse_clr();
      chk("clr_re", int'(out_re), 0);
      chk("clr_im", int'(out_im), 0);

      // wrap
      for (int i = 0; i < 5; i++) begin
         int e_im;
         e_im = 450 * (i + 1);
         if (e_im > 2047) e_im -= 4096;
         run_set("wrap", 4'd15, 4'd15, 4'd15, 4'd15, (i != 0), 0, e_im, 1'b1);
         chk("wrap_ovf", int'(ovf), (i == 4) ? 1 : 0);
      end
      pulse_clr();
      chk("clr_ovf", int'(ovf), 0);

      // timeout after a known result
      run_set("pre_tmo", 4'd2, 4'd2, 4'd1, 4'd2, 1'b0, -2, 6, 1'b1);
      s0 = n_start;
      hang_base = n_start;
      hang_en = 1'b1;
      send(4'd3, 4'd1, 4'd2, 4'd5, 1'b1);
      cyc = 0;
      saw = 0;
      while (!err && cyc < 100) begin
         tick();
         cyc++;
         if (out_valid) saw = 1;
      end
      chk("tmo_err", int'(err), 1);
      chk("tmo_wait_ge", int'(cyc >= TMO), 1);
      tick();
      chk("tmo_idle", int'(in_ready), 1);
      chk("tmo_novalid", saw | int'(out_valid), 0);
      chk("tmo_re", int'(out_re), -2);
      chk("tmo_im", int'(out_im), 6);
      chk("tmo_starts", n_start - s0, 2);
      hang_en = 1'b0;
      tick();
      pulse_clr();
      chk("clr_err", int'(err), 0);

      // reset during WAIT_HI of product 2
      run_set("pre_rst", 4'd2, 4'd3, 4'd2, 4'd1, 1'b0, 1, 8, 1'b1);
      s0 = n_start;
      send(4'd9, 4'd4, 4'd6, 4'd3, 1'b1);
      cyc = 0;
      while ((n_start - s0) < 3 && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("rst_reach_p2", n_start - s0, 3);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_ready", int'(in_ready), 1);
      chk("mid_rst_start", int'(mul_start), 0);
      chk("mid_rst_mul", int'({mul_a, mul_b}), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_re", int'(out_re), 0);
      chk("mid_rst_im", int'(out_im), 0);
      s1 = n_start;
      tick();
      rst = 1'b1;
      saw = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid) saw = 1;
      end
      chk("post_rst_starts", n_start - s1, 0);
      chk("post_rst_valid", saw, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_cplx_sched.md
MAC_CPLX_SCHED -- requirements
Module: mac_cplx_sched

Interface
REQ-001 Parameter ACC_W, default 12: signed accumulator width in bits, minimum 10.
REQ-002 Parameter TMO, default 16: maximum cycles to wait for a multiplier result after mul_start.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 in_ar, in_ai, in_br, in_bi  input  4 each  unsigned complex operands; A = ar + j*ai, B = br + j*bi.
REQ-008 in_acc  input  1  1 = add to accumulator; 0 = overwrite accumulator.
REQ-009 clr  input  1  clears the accumulators, ovf and err.
REQ-010 mul_start  output  1  one-cycle start pulse to the shared 4x4 multiplier.
REQ-011 mul_a, mul_b  output  4 each  multiplier operands.
REQ-012 mul_done  input  1  multiplier done level (high while the multiplier is idle).
REQ-013 mul_p  input  8  unsigned multiplier product.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_re, out_im  output  ACC_W each  signed accumulator values.
REQ-017 ovf  output  1  sticky flag: accumulator wrap occurred.
REQ-018 err  output  1  sticky flag: multiplier timeout.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_LO, WAIT_HI, COMBINE and OUT.
REQ-020 in_ready SHALL equal 1 only in IDLE; an operand set SHALL be accepted when in_valid && in_ready, which latches all operands and in_acc, clears product index k, and moves the FSM to ISSUE.
REQ-021 Product order for k = 0..3 SHALL be: p0 = ar*br, p1 = ai*bi, p2 = ar*bi, p3 = ai*br.
REQ-022 ISSUE SHALL assert mul_start for exactly one cycle with mul_a/mul_b set for product k, clear the timeout counter, and go to WAIT_LO.
REQ-023 mul_a/mul_b SHALL stay stable from ISSUE until product k is captured.
REQ-024 WAIT_LO SHALL wait for mul_done = 0, then go to WAIT_HI; mul_done is ignored in the ISSUE cycle.
REQ-025 WAIT_HI SHALL capture mul_p into pk on the first cycle with mul_done = 1; it then goes to ISSUE with k+1 if k < 3, otherwise to COMBINE.
REQ-026 The timeout counter SHALL increment every cycle in WAIT_LO and WAIT_HI.
REQ-027 If the timeout counter reaches TMO, the FSM SHALL set err, go to IDLE, leave the accumulators unchanged and not assert out_valid.
REQ-028 In COMBINE, re = p0 - p1 and im = p2 + p3, both computed in signed 10-bit precision.
REQ-029 In COMBINE, the accumulators SHALL load base + re and base + im, where base is the accumulator value if latched in_acc = 1 and 0 otherwise; results wrap modulo 2^ACC_W.
REQ-030 ovf SHALL be set when either ACC_W-bit sum differs from its exact value.
REQ-031 After COMBINE the FSM SHALL go to OUT; out_valid = 1 only in OUT, out_re/out_im SHALL hold steady there, and out_valid && out_ready SHALL return the FSM to IDLE in the same cycle.
REQ-032 Latency: for a multiplier whose done falls the cycle after start and stays low K cycles, out_valid SHALL first assert 4K+10 cycles after the accept cycle.
REQ-033 clr SHALL take effect only in IDLE, zeroing accumulators, ovf and err; it is ignored in all other states.
REQ-034 If clr and accept occur in the same IDLE cycle, clr SHALL apply first and the new set SHALL run with base 0.
REQ-035 Products SHALL never be issued concurrently; at most one mul_start pulse per operand set per product.

Reset
REQ-036 While rst = 0, the FSM SHALL be in IDLE, k = 0, timeout counter = 0, and all registers, accumulators, ovf and err = 0.
REQ-037 While rst = 0, outputs SHALL be: in_ready = 1, mul_start = 0, mul_a = mul_b = 0, out_valid = 0, out_re = out_im = 0.
REQ-038 Reset asserted mid-operation SHALL abort immediately with no further mul_start pulses.

Verification
REQ-039 Basic: A = 2+2j, B = 1+2j, in_acc = 0, multiplier model K = 3 -> out_re = -2, out_im = 6, out_valid 22 cycles after accept, exactly 4 mul_start pulses.
REQ-040 Accumulate: (2+3j)(2+1j) with in_acc = 0, then (1+0j)(1+3j) with in_acc = 1 -> first result (1, 8), then (2, 11).
REQ-041 Backpressure and clr: hold out_ready = 0 for 10 cycles -> outputs stable, in_ready = 0, new in_valid ignored; then clr in IDLE -> out_re = out_im = 0.
REQ-042 Wrap: ACC_W = 12, A = B = 15+15j, accumulated 5 times -> out_re = 0, out_im = -1846, ovf = 1.
REQ-043 Timeout: mul_done stuck high after the 2nd start -> err = 1 after TMO cycles, FSM in IDLE, no out_valid, accumulators unchanged.
REQ-044 Reset: rst low during WAIT_HI of product 2 -> all outputs at reset values next cycle, no further mul_start pulses.
